serial_adder: RTL and testbench

Parametrised, multi-cycle add/subtract unit built from a chain of one-bit full-adder cells. It processes `DIGIT` bits per clock over a `WIDTH`-bit operand pair and reports completion through a start/busy/done handshake. It also reports carry-out and signed overflow. It is the sequential, width-generic successor to the single-bit full adder, and serves datapaths that trade latency for area.

---
 rtl/serial_adder_pkg.sv | 7 +
 rtl/fa_cell.sv | 11 +
 rtl/serial_adder.sv | 88 ++++++++
 tb/tb_serial_adder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter sizing for serial_adder
package serial_adder_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational one-bit full adder
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic sum_o,
    output logic co_o
);
    assign sum_o = a_i ^ b_i ^ ci_i;
    assign co_o  = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract processing DIGIT bits per clock with start/busy/done handshake
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             co_o,
    output logic             ovf_o
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_w(N);
    if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
    end
    state_t           state, state_n;
    logic [WIDTH-1:0] a_r, b_r, acc, full;
    logic [CW-1:0]    cnt;
    logic             c_r, last;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] ps;
    assign c[0] = c_r;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        fa_cell u_fa (
            .a_i  (a_r[i]),
            .b_i  (b_r[i]),
            .ci_i (c[i]),
            .sum_o(ps[i]),
            .co_o (c[i+1])
        );
    end
    // partial sums enter from the MSB side so the result is aligned after N digits
    assign full = (acc >> DIGIT) | (WIDTH'(ps) << (WIDTH - DIGIT));
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n = (state == IDLE) ? (start_i ? RUN : IDLE) : (last ? IDLE : RUN);
    end
    always_comb begin
        busy_o = (state == RUN);
        last   = busy_o && (cnt == CW'(N - 1));
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            c_r    <= 1'b0;
            cnt    <= '0;
            sum_o  <= '0;
            co_o   <= 1'b0;
            ovf_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE && start_i) begin
                a_r <= a_i;
                b_r <= b_i ^ {WIDTH{sub_i}};
                c_r <= ci_i ^ sub_i;
                cnt <= '0;
            end else if (state == RUN) begin
                a_r <= a_r >> DIGIT;
                b_r <= b_r >> DIGIT;
                c_r <= c[DIGIT];
                acc <= full;
                cnt <= cnt + 1'b1;
                if (last) begin
                    sum_o  <= full;
                    co_o   <= c[DIGIT];
                    ovf_o  <= c[DIGIT] ^ c[DIGIT-1];
                    done_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench over three serial_adder configurations
module tb_serial_adder;
    typedef struct {
        int       d;
        logic [7:0] sum;
        logic     co;
        logic     ovf;
        int       cyc;
    } exp_t;

    localparam int NC [3] = '{8, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = '0, sub = '0, ci = '0;
    logic [7:0] a [3];
    logic [7:0] b [3];
    logic [2:0] busy, done, co, ovf;
    logic [7:0] sum8, sum4;
    logic       sum1;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    exp_t       q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .sub_i(sub[0]),
        .a_i(a[0]), .b_i(b[0]), .ci_i(ci[0]), .busy_o(busy[0]), .done_o(done[0]),
        .sum_o(sum8), .co_o(co[0]), .ovf_o(ovf[0]));
    serial_adder #(.WIDTH(1), .DIGIT(1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .sub_i(sub[1]),
        .a_i(a[1][0:0]), .b_i(b[1][0:0]), .ci_i(ci[1]), .busy_o(busy[1]), .done_o(done[1]),
        .sum_o(sum1), .co_o(co[1]), .ovf_o(ovf[1]));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d2 (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .sub_i(sub[2]),
        .a_i(a[2]), .b_i(b[2]), .ci_i(ci[2]), .busy_o(busy[2]), .done_o(done[2]),
        .sum_o(sum4), .co_o(co[2]), .ovf_o(ovf[2]));

    function automatic logic [7:0] sum_of(input int d);
        return (d == 0) ? sum8 : (d == 1) ? {7'b0, sum1} : sum4;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done[d] === 1'b1) begin
                if (q.size() == 0 || q[0].d != d) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d: got done=1 expected no completion", d);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", d, 32'(sum_of(d)), 32'(e.sum));
                    chk("co", d, 32'(co[d]), 32'(e.co));
                    chk("ovf", d, 32'(ovf[d]), 32'(e.ovf));
                    chk("latency", d, 32'(cyc), 32'(e.cyc));
                    chk("busy_at_done", d, 32'(busy[d]), 32'd0);
                end
            end
        end
    end

    // must be called at a falling edge; returns at the falling edge where done is high
    task automatic op(input int d, input logic s, input logic [7:0] av, input logic [7:0] bv,
                      input logic c, input logic [7:0] es, input logic eco, input logic eovf);
        int k;
        sub[d] = s; a[d] = av; b[d] = bv; ci[d] = c; start[d] = 1'b1;
        q.push_back('{d: d, sum: es, co: eco, ovf: eovf, cyc: cyc + 1 + NC[d]});
        @(negedge clk);
        start[d] = 1'b0;
        chk("busy_after_start", d, 32'(busy[d]), 32'd1);
        k = 0;
        while (done[d] !== 1'b1 && k < NC[d] + 4) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", d, 32'(done[d]), 32'd1);
    endtask

    localparam logic [2:0] TT [8] = '{3'b000, 3'b101, 3'b100, 3'b010,
                                      3'b100, 3'b010, 3'b011, 3'b110};

    initial begin
        for (int d = 0; d < 3; d++) begin a[d] = '0; b[d] = '0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", d, 32'(busy[d]), 32'd0);
            chk("rst_done", d, 32'(done[d]), 32'd0);
            chk("rst_sum", d, 32'(sum_of(d)), 32'd0);
            chk("rst_co_ovf", d, 32'({co[d], ovf[d]}), 32'd0);
        end
        @(negedge clk);
        op(0, 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        op(0, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op(0, 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
        op(0, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        op(0, 1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v, t;
            v = 3'(i);
            t = TT[i];
            op(1, 1'b0, {7'b0, v[2]}, {7'b0, v[1]}, v[0], {7'b0, t[2]}, t[1], t[0]);
        end
        @(negedge clk);
        op(2, 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        op(2, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        // second start while running must be ignored
        sub[2] = 1'b0; a[2] = 8'h5A; b[2] = 8'h3C; ci[2] = 1'b0; start[2] = 1'b1;
        q.push_back('{d: 2, sum: 8'h96, co: 1'b0, ovf: 1'b1, cyc: cyc + 1 + NC[2]});
        @(negedge clk);
        a[2] = 8'h11; b[2] = 8'h22; ci[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        repeat (4) @(negedge clk);
        chk("ignored_start_busy", 2, 32'(busy[2]), 32'd0);
        op(2, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);
        sub[2] = 1'b0; a[2] = 8'h70; b[2] = 8'h70; ci[2] = 1'b0; start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 2, 32'(busy[2]), 32'd0);
        chk("abort_sum", 2, 32'(sum4), 32'd0);
        chk("abort_co_ovf", 2, 32'({co[2], ovf[2]}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 2, 32'(done[2]), 32'd0);
            @(negedge clk);
        end
        op(2, 1'b0, 8'h70, 8'h70, 1'b0, 8'hE0, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        chk("scoreboard_drained", 0, 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
